// File: rtl/alu_arbiter_ctrl_if.sv
// Requester/response bundle for alu_arbiter_ctrl.
// The slave modport is the controller side; master is the requester/consumer side.
interface alu_arbiter_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic             req0_op;
  logic [2:0]       req0_a;
  logic [2:0]       req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic             req1_op;
  logic [2:0]       req1_a;
  logic [2:0]       req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [5:0]       rsp_data;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, busy, op_count
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, busy, op_count
  );
endinterface

// File: rtl/alu_arbiter_ctrl.sv
// Two-requester round-robin front end for a tiny ALU: 1-cycle add,
// 3-cycle shift-add multiply, held response and saturating completion count.
module alu_arbiter_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_arbiter_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           r_state,     w_state_n;
  logic             r_ptr,       w_ptr_n;
  logic             r_op,        w_op_n;
  logic [2:0]       r_a,         w_a_n;
  logic [2:0]       r_b,         w_b_n;
  logic             r_id,        w_id_n;
  logic [5:0]       r_acc,       w_acc_n;
  logic [1:0]       r_step,      w_step_n;
  logic             r_rsp_valid, w_rsp_valid_n;
  logic             r_rsp_id,    w_rsp_id_n;
  logic [5:0]       r_rsp_data,  w_rsp_data_n;
  logic             r_busy,      w_busy_n;
  logic [CNT_W-1:0] r_op_count,  w_op_count_n;

  logic       w_idle;
  logic       w_gnt0;
  logic       w_gnt1;
  logic [5:0] w_term;

  // Grant is combinational in IDLE; the pointer only breaks ties.
  assign w_idle = (r_state == S_IDLE) && !rst;
  assign w_gnt0 = bus.req0_valid && (!bus.req1_valid || !r_ptr);
  assign w_gnt1 = bus.req1_valid && (!bus.req0_valid ||  r_ptr);

  assign bus.req0_ready = w_idle && w_gnt0;
  assign bus.req1_ready = w_idle && w_gnt1;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.busy       = r_busy;
  assign bus.op_count   = r_op_count;

  // Partial product for the operand-b bit selected by the step counter.
  assign w_term = r_b[r_step] ? (6'(r_a) << r_step) : 6'd0;

  always_comb begin
    w_state_n     = r_state;
    w_ptr_n       = r_ptr;
    w_op_n        = r_op;
    w_a_n         = r_a;
    w_b_n         = r_b;
    w_id_n        = r_id;
    w_acc_n       = r_acc;
    w_step_n      = r_step;
    w_rsp_valid_n = r_rsp_valid;
    w_rsp_id_n    = r_rsp_id;
    w_rsp_data_n  = r_rsp_data;
    w_busy_n      = r_busy;
    w_op_count_n  = r_op_count;

    unique case (r_state)
      S_IDLE: begin
        if (bus.req0_ready || bus.req1_ready) begin
          w_op_n    = bus.req1_ready ? bus.req1_op : bus.req0_op;
          w_a_n     = bus.req1_ready ? bus.req1_a  : bus.req0_a;
          w_b_n     = bus.req1_ready ? bus.req1_b  : bus.req0_b;
          w_id_n    = bus.req1_ready;
          w_ptr_n   = !bus.req1_ready;
          w_acc_n   = 6'd0;
          w_step_n  = 2'd0;
          w_busy_n  = 1'b1;
          w_state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_op) begin
          w_rsp_data_n  = 6'(r_a) + 6'(r_b);
          w_rsp_id_n    = r_id;
          w_rsp_valid_n = 1'b1;
          w_state_n     = S_RESP;
        end else begin
          w_acc_n  = r_acc + w_term;
          w_step_n = r_step + 2'd1;
          if (r_step == 2'd2) begin
            w_rsp_data_n  = r_acc + w_term;
            w_rsp_id_n    = r_id;
            w_rsp_valid_n = 1'b1;
            w_state_n     = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_n = 1'b0;
          w_rsp_id_n    = 1'b0;
          w_rsp_data_n  = 6'd0;
          w_busy_n      = 1'b0;
          w_state_n     = S_IDLE;
          if (r_op_count != {CNT_W{1'b1}}) begin
            w_op_count_n = r_op_count + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_op        <= 1'b0;
      r_a         <= 3'd0;
      r_b         <= 3'd0;
      r_id        <= 1'b0;
      r_acc       <= 6'd0;
      r_step      <= 2'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= 6'd0;
      r_busy      <= 1'b0;
      r_op_count  <= '0;
    end else begin
      r_state     <= w_state_n;
      r_ptr       <= w_ptr_n;
      r_op        <= w_op_n;
      r_a         <= w_a_n;
      r_b         <= w_b_n;
      r_id        <= w_id_n;
      r_acc       <= w_acc_n;
      r_step      <= w_step_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_id    <= w_rsp_id_n;
      r_rsp_data  <= w_rsp_data_n;
      r_busy      <= w_busy_n;
      r_op_count  <= w_op_count_n;
    end
  end

endmodule
